window_gen_line_buffer: RTL and testbench

//  Raster-to-window converter feeding the 7x7 spatial filter stage.

---
 rtl/window_gen_line_buffer_if.sv | 19 +
 rtl/window_gen_line_buffer.sv | 96 +++++++++
 tb/tb_window_gen_line_buffer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/window_gen_line_buffer_if.sv
// Pixel-in / window-out bus between the raster source and the window generator.
interface window_gen_line_buffer_if #(
  parameter int PIX_BIT    = 8,
  parameter int MASK_WIDTH = 7
);
  logic [PIX_BIT-1:0]                       pix_in;
  logic                                     pix_valid;
  logic                                     sof;
  logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0] win_p;
  logic                                     win_valid;
  logic                                     frame_done;

  // master: raster source driving pixels and consuming windows
  modport master (output pix_in, pix_valid, sof,
                  input  win_p, win_valid, frame_done);
  // slave: the window generator itself
  modport slave  (input  pix_in, pix_valid, sof,
                  output win_p, win_valid, frame_done);
endinterface

// File: rtl/window_gen_line_buffer.sv
// Raster-to-window converter: MASK_WIDTH-1 line buffers plus a MxM shift
// window. It emits only interior windows, with no border padding.
module window_gen_line_buffer #(
  parameter int PIX_BIT    = 8,
  parameter int MASK_WIDTH = 7,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                     clk,
  input  logic                     reset_n,
  window_gen_line_buffer_if.slave  bus
);
  localparam int M     = MASK_WIDTH;
  localparam int NLB   = M - 1;
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_EDGE = COL_W'(M - 1);
  localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(M - 1);

  logic                            accept;
  logic [COL_W-1:0]                col, pcol;
  logic [ROW_W-1:0]                row, prow;
  logic [NLB-1:0][PIX_BIT-1:0]     lb_rd;
  logic [M-1:0][PIX_BIT-1:0]       col_vec;
  logic [M-1:0][M-1:0][PIX_BIT-1:0] win_q;   // [r][c], flattens to i=r*M+c
  logic                            win_valid_q, frame_done_q;

  assign accept = bus.pix_valid;
  // sof forces the current pixel to (0,0) regardless of where the counters are
  assign pcol = bus.sof ? '0 : col;
  assign prow = bus.sof ? '0 : row;

  // Line buffers form a vertical chain: each one passes its old column entry down a line.
  for (genvar k = 0; k < NLB; k++) begin : g_lb
    logic [PIX_BIT-1:0] mem [IMG_WIDTH];
    logic [PIX_BIT-1:0] wr;
    assign lb_rd[k] = mem[pcol];
    if (k == 0) begin : g_head
      assign wr = bus.pix_in;
    end else begin : g_tail
      assign wr = lb_rd[k-1];
    end
    // read-before-write: lb_rd reflects the previous content of this column
    always_ff @(posedge clk)
      if (accept) mem[pcol] <= wr;
  end

  // New rightmost column: oldest line (deepest buffer) on top, live pixel at bottom.
  always_comb begin
    col_vec        = '0;
    col_vec[M-1]   = bus.pix_in;
    for (int r = 0; r < M - 1; r++) col_vec[r] = lb_rd[M-2-r];
  end

  // Raster position, plus the registered window-valid and frame-done pulses.
  // After any sof or reset, row>=M-1 guarantees every buffered line belongs
  // to the current frame, so stale data never reaches a valid window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col          <= '0;
      row          <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= accept && (prow >= ROW_EDGE) && (pcol >= COL_EDGE);
      frame_done_q <= accept && (prow == ROW_LAST) && (pcol == COL_LAST);
      if (accept) begin
        if (pcol == COL_LAST) begin
          col <= '0;
          row <= (prow == ROW_LAST) ? '0 : prow + 1'b1;
        end else begin
          col <= pcol + 1'b1;
          row <= prow;
        end
      end
    end
  end

  // Window shift: columns move left on each accept, and col_vec enters on the right.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q <= '0;
    end else if (accept) begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < M - 1; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][M-1] <= col_vec[r];
      end
    end
  end

  assign bus.win_p      = win_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_window_gen_line_buffer.sv
// Bench for window_gen_line_buffer on a 16x12 image with a 7x7 window.
// Reference: accepted pixels are stored in an image array at their raster position;
// each expected window is the 7x7 patch ending at the accepted pixel.
module tb_window_gen_line_buffer;
  localparam int P = 8, M = 7, W = 16, H = 12;
  localparam int WB   = P * M * M;
  localparam int NWIN = (W - M + 1) * (H - M + 1);

  logic clk = 1'b0, clk_en = 1'b0, reset_n = 1'b1;

  window_gen_line_buffer_if #(.PIX_BIT(P), .MASK_WIDTH(M)) bus ();

  window_gen_line_buffer #(
    .PIX_BIT(P), .MASK_WIDTH(M), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_pass = 0;
  int mr = 0, mc = 0;                 // model raster position of the next pixel
  logic [P-1:0] img [H][W];
  int pulses;
  bit done_with_valid;
  logic [WB-1:0] first_win, last_win, ref_first, ref_last;

  task automatic chk(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  // Drive one cycle, then check the DUT against the image model.
  task automatic step(input bit v, input bit s, input logic [P-1:0] px);
    bit ev, ed;
    logic [WB-1:0] ew;
    bus.pix_valid = v; bus.sof = s; bus.pix_in = px;
    @(posedge clk); #1;
    ev = 0; ed = 0; ew = '0;
    if (v) begin
      if (s) begin mr = 0; mc = 0; end
      img[mr][mc] = px;
      ev = (mr >= M - 1) && (mc >= M - 1);
      ed = (mr == H - 1) && (mc == W - 1);
      if (ev)
        for (int rr = 0; rr < M; rr++)
          for (int cc = 0; cc < M; cc++)
            ew[(rr*M+cc)*P +: P] = img[mr-M+1+rr][mc-M+1+cc];
      mc++;
      if (mc == W) begin mc = 0; mr++; if (mr == H) mr = 0; end
    end
    chk("win_valid", WB'(bus.win_valid), WB'(ev));
    chk("frame_done", WB'(bus.frame_done), WB'(ed));
    if (ev) chk("win_p", bus.win_p, ew);
    if (bus.win_valid) begin
      if (pulses == 0) first_win = bus.win_p;
      last_win = bus.win_p;
      pulses++;
      if (bus.frame_done) done_with_valid = 1;
    end
    bus.pix_valid = 0; bus.sof = 0;
  endtask

  // Stream a frame from (0,0) with sof on the first pixel. The stream stops before
  // pixel index stop_at, or runs the whole frame if stop_at is negative. With gaps=1,
  // idle cycles are inserted at random, sometimes carrying a stray unqualified sof.
  task automatic frame(input bit gaps, input int stop_at);
    int r, c;
    pulses = 0; done_with_valid = 0;
    for (int n = 0; n < H * W; n++) begin
      if (n == stop_at) break;
      if (gaps && $urandom_range(1) == 1)
        step(1'b0, 1'($urandom_range(1)), P'($urandom));
      r = n / W; c = n % W;
      step(1'b1, n == 0, P'((r * 16 + c) & 8'hFF));
    end
  endtask

  initial begin
    bus.pix_in = '0; bus.pix_valid = 1'b0; bus.sof = 1'b0;
    first_win = '0; last_win = '0; pulses = 0;

    // 1: reset with no clock running
    #2 reset_n = 1'b0;
    #1;
    chk("rst_win_p", bus.win_p, '0);
    chk("rst_win_valid", WB'(bus.win_valid), '0);
    chk("rst_frame_done", WB'(bus.frame_done), '0);
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // 2: continuous frame
    frame(1'b0, -1);
    chk("t2_pulses", WB'(pulses), WB'(NWIN));
    chk("t2_first_i0", WB'(first_win[0*P +: P]), WB'(0));
    chk("t2_first_i24", WB'(first_win[24*P +: P]), WB'(51));
    chk("t2_first_i48", WB'(first_win[48*P +: P]), WB'(102));
    ref_first = first_win; ref_last = last_win;

    // 3: random pix_valid gaps
    frame(1'b1, -1);
    chk("t3_pulses", WB'(pulses), WB'(NWIN));
    chk("t3_first", first_win, ref_first);
    chk("t3_last", last_win, ref_last);

    // 4: back-to-back frames, with the last window ending at (11,15)
    frame(1'b0, -1);
    chk("t4_done_with_valid", WB'(done_with_valid), WB'(1));
    chk("t4_last_i48", WB'(last_win[48*P +: P]), WB'(11 * 16 + 15));
    // The top-left of the final window is (5,9).
    chk("t4_last_i0", WB'(last_win[0*P +: P]), WB'(5 * 16 + 9));
    frame(1'b0, -1);
    chk("t4b_pulses", WB'(pulses), WB'(NWIN));
    chk("t4b_first", first_win, ref_first);
    chk("t4b_last", last_win, ref_last);

    // 5: sof raised at old (4,9), then a full new frame
    frame(1'b0, 4 * W + 9);
    frame(1'b0, -1);
    chk("t5_pulses", WB'(pulses), WB'(NWIN));
    chk("t5_first_i0", WB'(first_win[0*P +: P]), WB'(0));
    chk("t5_first", first_win, ref_first);

    // 6: reset pulse mid-line at (8,3), then restart with sof
    frame(1'b0, 8 * W + 3);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_win_p", bus.win_p, '0);
    chk("t6_rst_win_valid", WB'(bus.win_valid), '0);
    chk("t6_rst_frame_done", WB'(bus.frame_done), '0);
    @(posedge clk); #1;
    chk("t6_rst_hold_win_p", bus.win_p, '0);
    chk("t6_rst_hold_valid", WB'(bus.win_valid), '0);
    reset_n = 1'b1;
    mr = 0; mc = 0;
    frame(1'b0, -1);
    chk("t6_pulses", WB'(pulses), WB'(NWIN));
    chk("t6_first", first_win, ref_first);
    chk("t6_last", last_win, ref_last);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
